rgb_channel_splitter: RTL and testbench

Source-side companion to the Gaussian filter. It accepts a packed 24-bit RGB pixel stream on a busy/vld handshake and fans it out to three independent 8-bit channel streams (R, G, B), each with its own busy/vld handshake, so it can drive the filter's `i_r`/`i_g`/`i_b` inputs. A small per-channel FIFO decouples the channels, so one stalled channel does not block the others until its FIFO fills.

---
 rtl/gau_pix_pkg.sv | 17 +
 rtl/chan_fifo.sv | 66 ++++++
 rtl/rgb_channel_splitter.sv | 87 ++++++++
 tb/tb_rgb_channel_splitter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gau_pix_pkg.sv
// Shared pixel definitions for the Gaussian filter path: lane widths,
// byte-lane offsets and the packed RGB pixel layout (R in the low byte).
package gau_pix_pkg;

  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int R_LSB = 0;
  localparam int G_LSB = 8;
  localparam int B_LSB = 16;

  typedef struct packed {
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
  } rgb_pix_t;

endpackage

// File: rtl/chan_fifo.sv
// Single-channel FIFO: register-array storage, pops itself whenever its sink
// is ready, and reports full/empty from the registered occupancy count.
module chan_fifo
  import gau_pix_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CH_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_busy,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_vld   = ~o_empty;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = ~o_empty & ~i_busy;

  // Head is forced to zero when empty so stale contents never leak out.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_channel_splitter.sv
// Fans a packed 24-bit RGB stream out to three independently handshaked 8-bit
// channel streams; a pixel is accepted only when every channel FIFO has room.
module rgb_channel_splitter
  import gau_pix_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             i_pix_busy,
  input  logic             i_pix_vld,
  input  logic [PIX_W-1:0] i_pix_data,
  input  logic             o_r_busy,
  input  logic             o_g_busy,
  input  logic             o_b_busy,
  output logic             o_r_vld,
  output logic             o_g_vld,
  output logic             o_b_vld,
  output logic [CH_W-1:0]  o_r_data,
  output logic [CH_W-1:0]  o_g_data,
  output logic [CH_W-1:0]  o_b_data,
  output logic [CNT_W-1:0] o_pix_count
);

  rgb_pix_t         w_pix;
  logic             w_accept;
  logic             w_r_full;
  logic             w_g_full;
  logic             w_b_full;
  logic             w_r_empty;
  logic             w_g_empty;
  logic             w_b_empty;
  logic [CNT_W-1:0] r_pix_count;

  assign w_pix       = i_pix_data;
  // Full flags come straight from registered counts, so sink busy never
  // reaches the producer combinationally.
  assign i_pix_busy  = w_r_full | w_g_full | w_b_full;
  assign w_accept    = i_pix_vld & ~i_pix_busy;
  assign o_pix_count = r_pix_count;

  chan_fifo #(.DEPTH(DEPTH), .WIDTH(CH_W)) u_r_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_accept),
    .i_data  (w_pix.r),
    .i_busy  (o_r_busy),
    .o_vld   (o_r_vld),
    .o_data  (o_r_data),
    .o_full  (w_r_full),
    .o_empty (w_r_empty)
  );

  chan_fifo #(.DEPTH(DEPTH), .WIDTH(CH_W)) u_g_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_accept),
    .i_data  (w_pix.g),
    .i_busy  (o_g_busy),
    .o_vld   (o_g_vld),
    .o_data  (o_g_data),
    .o_full  (w_g_full),
    .o_empty (w_g_empty)
  );

  chan_fifo #(.DEPTH(DEPTH), .WIDTH(CH_W)) u_b_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_accept),
    .i_data  (w_pix.b),
    .i_busy  (o_b_busy),
    .o_vld   (o_b_vld),
    .o_data  (o_b_data),
    .o_full  (w_b_full),
    .o_empty (w_b_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pix_count <= '0;
    end else if (w_accept) begin
      r_pix_count <= r_pix_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rgb_channel_splitter.sv
// Directed bench for rgb_channel_splitter: per-channel expected-byte queues
// plus hand-computed checks for reset, latency, stall, mid-run reset and wrap.
module tb_rgb_channel_splitter;

  logic        clk;
  logic        rstN;
  logic        pixBusy;
  logic        pixVld;
  logic [23:0] pixData;
  logic        rBusy, gBusy, bBusy;
  logic        rVld, gVld, bVld;
  logic [7:0]  rData, gData, bData;
  logic [31:0] pixCount;

  logic        pixBusy4;
  logic        rVld4, gVld4, bVld4;
  logic [7:0]  rData4, gData4, bData4;
  logic [3:0]  pixCount4;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rQ[$];
  logic [7:0]  gQ[$];
  logic [7:0]  bQ[$];
  int          rBeats, gBeats, bBeats;

  rgb_channel_splitter #(.DEPTH(4), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rstN), .i_pix_busy(pixBusy), .i_pix_vld(pixVld),
    .i_pix_data(pixData), .o_r_busy(rBusy), .o_g_busy(gBusy), .o_b_busy(bBusy),
    .o_r_vld(rVld), .o_g_vld(gVld), .o_b_vld(bVld),
    .o_r_data(rData), .o_g_data(gData), .o_b_data(bData), .o_pix_count(pixCount)
  );

  // Narrow-counter twin sharing every input, used for the wrap check.
  rgb_channel_splitter #(.DEPTH(4), .CNT_W(4)) dutWrap (
    .i_clk(clk), .i_rst(rstN), .i_pix_busy(pixBusy4), .i_pix_vld(pixVld),
    .i_pix_data(pixData), .o_r_busy(rBusy), .o_g_busy(gBusy), .o_b_busy(bBusy),
    .o_r_vld(rVld4), .o_g_vld(gVld4), .o_b_vld(bVld4),
    .o_r_data(rData4), .o_g_data(gData4), .o_b_data(bData4), .o_pix_count(pixCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [23:0] data);
    pixVld  = vld;
    pixData = data;
  endtask

  // One clock: scoreboard beats and acceptances at the falling edge, then
  // return #1 after the rising edge where the handshakes took effect.
  task automatic stepCycle(output bit accepted, input bit chkBusy, input bit expBusy);
    @(negedge clk);
    accepted = pixVld && !pixBusy;
    if (chkBusy) checkOutput("pix_busy", {31'd0, pixBusy}, {31'd0, expBusy});
    if (rVld && !rBusy) begin
      rBeats++;
      if (rQ.size() == 0) checkOutput("r_unexpected_vld", {31'd0, rVld}, 32'd0);
      else checkOutput("r_data", {24'd0, rData}, {24'd0, rQ.pop_front()});
    end
    if (gVld && !gBusy) begin
      gBeats++;
      if (gQ.size() == 0) checkOutput("g_unexpected_vld", {31'd0, gVld}, 32'd0);
      else checkOutput("g_data", {24'd0, gData}, {24'd0, gQ.pop_front()});
    end
    if (bVld && !bBusy) begin
      bBeats++;
      if (bQ.size() == 0) checkOutput("b_unexpected_vld", {31'd0, bVld}, 32'd0);
      else checkOutput("b_data", {24'd0, bData}, {24'd0, bQ.pop_front()});
    end
    if (accepted) begin
      rQ.push_back(pixData[7:0]);
      gQ.push_back(pixData[15:8]);
      bQ.push_back(pixData[23:16]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, pixBusy}, 32'd0);
    checkOutput({tag, "_vld"}, {29'd0, rVld, gVld, bVld}, 32'd0);
    checkOutput({tag, "_data"}, {8'd0, bData, gData, rData}, 32'd0);
    checkOutput({tag, "_count"}, pixCount, 32'd0);
    checkOutput({tag, "_count4"}, {28'd0, pixCount4}, 32'd0);
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pixVld  = 1'($urandom);
      pixData = 24'($urandom);
      rBusy   = 1'($urandom);
      gBusy   = 1'($urandom);
      bBusy   = 1'($urandom);
      @(negedge clk);
      checkIdle("in_reset");
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 24'd0);
    rBusy = 1'b0;
    gBusy = 1'b0;
    bBusy = 1'b0;
    rQ.delete();
    gQ.delete();
    bQ.delete();
    rBeats = 0;
    gBeats = 0;
    bBeats = 0;
    rstN = 1'b1;
  endtask

  initial begin
    bit acc;
    int idx;
    int gPend;
    rstN = 1'b0;
    applyStimulus(1'b0, 24'd0);
    rBusy = 1'b0;
    gBusy = 1'b0;
    bBusy = 1'b0;
    @(posedge clk);
    #1;

    applyReset();
    for (int i = 0; i < 3; i++) stepCycle(acc, 1'b1, 1'b0);
    checkIdle("after_release");

    // Single pixel: visible the cycle after acceptance, gone one cycle later.
    applyStimulus(1'b1, 24'h332211);
    stepCycle(acc, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h332211);
    checkOutput("single_vld", {29'd0, rVld, gVld, bVld}, 32'h7);
    checkOutput("single_r", {24'd0, rData}, 32'h11);
    checkOutput("single_g", {24'd0, gData}, 32'h22);
    checkOutput("single_b", {24'd0, bData}, 32'h33);
    stepCycle(acc, 1'b1, 1'b0);
    checkOutput("single_vld_after", {29'd0, rVld, gVld, bVld}, 32'h0);
    checkOutput("single_count", pixCount, 32'd1);

    // Back-to-back streaming with ready sinks.
    applyReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, {8'(i + 1), 8'(i) ^ 8'hFF, 8'(i)});
      stepCycle(acc, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 24'd0);
    for (int i = 0; i < 3; i++) stepCycle(acc, 1'b1, 1'b0);
    checkOutput("stream_r_beats", rBeats, 32'd256);
    checkOutput("stream_g_beats", gBeats, 32'd256);
    checkOutput("stream_b_beats", bBeats, 32'd256);
    checkOutput("stream_count", pixCount, 32'd256);

    // G stalled for 20 cycles; busy must rise once G holds DEPTH bytes.
    gBusy = 1'b1;
    idx   = 0;
    gPend = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, {8'(idx + 8'hA0), 8'(idx + 8'h50), 8'(idx + 8'h10)});
      stepCycle(acc, 1'b1, gPend == 4);
      if (acc) begin
        idx++;
        gPend++;
      end
    end
    applyStimulus(1'b0, 24'd0);
    checkOutput("stall_r_drained", rQ.size(), 32'd0);
    checkOutput("stall_b_drained", bQ.size(), 32'd0);
    checkOutput("stall_g_pending", gQ.size(), 32'd4);
    checkOutput("stall_vld", {29'd0, rVld, gVld, bVld}, 32'h2);
    checkOutput("stall_count", pixCount, 32'd260);
    gBusy = 1'b0;
    for (int i = 0; i < 6; i++) stepCycle(acc, 1'b0, 1'b0);
    checkOutput("stall_g_released", gQ.size(), 32'd0);
    checkOutput("stall_g_beats", gBeats, 32'd260);
    checkOutput("stall_busy_clear", {31'd0, pixBusy}, 32'd0);

    // Reset with every FIFO half full: vld drops at once, nothing stale later.
    rBusy = 1'b1;
    gBusy = 1'b1;
    bBusy = 1'b1;
    applyStimulus(1'b1, 24'hCCBBAA);
    stepCycle(acc, 1'b1, 1'b0);
    applyStimulus(1'b1, 24'hFFEEDD);
    stepCycle(acc, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'd0);
    checkOutput("half_full_vld", {29'd0, rVld, gVld, bVld}, 32'h7);
    rstN = 1'b0;
    #1;
    checkOutput("async_drop_vld", {29'd0, rVld, gVld, bVld}, 32'h0);
    checkOutput("async_drop_count", pixCount, 32'd0);
    applyReset();
    for (int i = 0; i < 4; i++) stepCycle(acc, 1'b1, 1'b0);
    checkIdle("post_reset");

    // Counter wrap on the 4-bit twin: 15, 0, 1 after pixels 15, 16, 17.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, {8'(i), 8'(i + 3), 8'(i + 7)});
      stepCycle(acc, 1'b1, 1'b0);
      if (i >= 14) checkOutput("wrap_count4", {28'd0, pixCount4}, 32'((i + 1) % 16));
    end
    applyStimulus(1'b0, 24'd0);
    for (int i = 0; i < 3; i++) stepCycle(acc, 1'b1, 1'b0);
    checkOutput("wrap_count32", pixCount, 32'd17);
    checkOutput("wrap_r_beats", rBeats, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
